// File: rtl/wb_trace_buffer_if.sv
// Read-side port of the writeback trace buffer.
// The buffer (master) presents the head entry and its valid flag.
// The debug host (slave) answers with rd_ready.
//   rd_valid  head entry available
//   rd_ready  host accepts the head entry at the next rising edge
//   rd_seq    sequence tag of the head entry
//   rd_exc    exception code of the head entry
//   rd_reg    destination register of the head entry
//   rd_data   write data of the head entry
interface wb_trace_buffer_if #(
   parameter int SEQ_W = 16
);
   logic             rd_valid;
   logic             rd_ready;
   logic [SEQ_W-1:0] rd_seq;
   logic [2:0]       rd_exc;
   logic [4:0]       rd_reg;
   logic [31:0]      rd_data;

   modport master (
      output rd_valid, rd_seq, rd_exc, rd_reg, rd_data,
      input  rd_ready
   );

   modport slave (
      input  rd_valid, rd_seq, rd_exc, rd_reg, rd_data,
      output rd_ready
   );
endinterface

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: taps the WB stage and queues every architectural
// writeback or exception event in a FIFO that a debug host drains over a
// valid/ready port.
// Ports:
//   SYS_clk, SYS_reset     clock (rising edge) and async active-low reset
//   WB_*                   writeback stage tap (reg-write, dest, data, exc code)
//   trace_enable           capture enable (OFF <-> RUN)
//   freeze_on_exc          stop capturing after the first captured exception
//   clear                  synchronous flush of FIFO, counters and flags
//   rd                     head-entry read port (wb_trace_buffer_if.master)
//   fill_level             number of entries held
//   overflow               sticky: at least one event was dropped
//   dropped_count          saturating count of dropped events
//   frozen                 capture stopped by an exception
module wb_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int SEQ_W = 16
) (
   input  logic                     SYS_clk,
   input  logic                     SYS_reset,
   input  logic                     WB_RegWrite_signal,
   input  logic [4:0]               WB_write_register,
   input  logic [31:0]              WB_write_data,
   input  logic [2:0]               WB_exception_signal,
   input  logic                     trace_enable,
   input  logic                     freeze_on_exc,
   input  logic                     clear,
   wb_trace_buffer_if.master        rd,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     overflow,
   output logic [SEQ_W-1:0]         dropped_count,
   output logic                     frozen
);

   localparam int PW = $clog2(DEPTH);
   localparam int FW = PW + 1;
   localparam int EW = SEQ_W + 3 + 5 + 32;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2
   } state_t;

   state_t           state_r;
   logic [EW-1:0]    mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [FW-1:0]    fill_r;
   logic [SEQ_W-1:0] seq_r;
   logic [SEQ_W-1:0] drop_cnt_r;
   logic             overflow_r;
   logic             frozen_r;

   logic             event_s;
   logic             capture_s;
   logic             pop_s;
   logic             full_s;
   logic             store_s;
   logic             drop_s;
   logic             freeze_s;
   logic [EW-1:0]    head_s;

   assign event_s   = (WB_RegWrite_signal && (WB_write_register != 5'd0)) ||
                      (WB_exception_signal != 3'd0);
   assign capture_s = (state_r == ST_RUN) && event_s;
   assign pop_s     = (fill_r != {FW{1'b0}}) && rd.rd_ready;
   assign full_s    = (fill_r == FW'(DEPTH));
   // A pop on the same edge frees the slot the incoming event needs.
   assign store_s   = capture_s && (!full_s || pop_s);
   assign drop_s    = capture_s && full_s && !pop_s;
   assign freeze_s  = capture_s && (WB_exception_signal != 3'd0) && freeze_on_exc;

   // Head entry is read straight from storage; nothing bypasses the FIFO.
   assign head_s        = mem_r[rd_ptr_r];
   assign rd.rd_valid   = (fill_r != {FW{1'b0}});
   assign rd.rd_seq     = head_s[EW-1 -: SEQ_W];
   assign rd.rd_exc     = head_s[39:37];
   assign rd.rd_reg     = head_s[36:32];
   assign rd.rd_data    = head_s[31:0];
   assign fill_level    = fill_r;
   assign overflow      = overflow_r;
   assign dropped_count = drop_cnt_r;
   assign frozen        = frozen_r;

   // FIFO storage, pointers, fill level, sequence tag and drop accounting.
   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {EW{1'b0}};
         end
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         fill_r     <= {FW{1'b0}};
         seq_r      <= {SEQ_W{1'b0}};
         drop_cnt_r <= {SEQ_W{1'b0}};
         overflow_r <= 1'b0;
      end else if (clear) begin
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         fill_r     <= {FW{1'b0}};
         seq_r      <= {SEQ_W{1'b0}};
         drop_cnt_r <= {SEQ_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (store_s) begin
            mem_r[wr_ptr_r] <= {seq_r, WB_exception_signal, WB_write_register, WB_write_data};
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         if (store_s && !pop_s) begin
            fill_r <= fill_r + FW'(1);
         end else if (pop_s && !store_s) begin
            fill_r <= fill_r - FW'(1);
         end else begin
            fill_r <= fill_r;
         end
         // Dropped events still consume a tag so the host sees the gap.
         if (capture_s) begin
            seq_r <= seq_r + SEQ_W'(1);
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != {SEQ_W{1'b1}}) begin
               drop_cnt_r <= drop_cnt_r + SEQ_W'(1);
            end
         end
      end
   end

   // Capture control FSM; frozen is registered alongside the state.
   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         state_r  <= ST_OFF;
         frozen_r <= 1'b0;
      end else if (clear) begin
         state_r  <= ST_OFF;
         frozen_r <= 1'b0;
      end else begin
         case (state_r)
            ST_OFF: begin
               if (trace_enable) begin
                  state_r <= ST_RUN;
               end
               frozen_r <= 1'b0;
            end
            ST_RUN: begin
               // Freezing wins over a simultaneous disable.
               if (freeze_s) begin
                  state_r  <= ST_FROZEN;
                  frozen_r <= 1'b1;
               end else if (!trace_enable) begin
                  state_r  <= ST_OFF;
                  frozen_r <= 1'b0;
               end else begin
                  frozen_r <= 1'b0;
               end
            end
            ST_FROZEN: begin
               frozen_r <= 1'b1;
            end
            default: begin
               state_r  <= ST_OFF;
               frozen_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;
   localparam int DEPTH = 16;
   localparam int SEQ_W = 16;

   logic        SYS_clk = 1'b0;
   logic        SYS_reset = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  wreg = 5'd0;
   logic [31:0] wdata = 32'd0;
   logic [2:0]  wexc = 3'd0;
   logic        en = 1'b0;
   logic        frz = 1'b0;
   logic        clr = 1'b0;
   logic [4:0]  fill_level;
   logic        overflow;
   logic [15:0] dropped_count;
   logic        frozen;

   wb_trace_buffer_if #(.SEQ_W(SEQ_W)) rd_if ();

   wb_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .SYS_clk            (SYS_clk),
      .SYS_reset          (SYS_reset),
      .WB_RegWrite_signal (we),
      .WB_write_register  (wreg),
      .WB_write_data      (wdata),
      .WB_exception_signal(wexc),
      .trace_enable       (en),
      .freeze_on_exc      (frz),
      .clear              (clr),
      .rd                 (rd_if.master),
      .fill_level         (fill_level),
      .overflow           (overflow),
      .dropped_count      (dropped_count),
      .frozen             (frozen)
   );

   always #5 SYS_clk = ~SYS_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: entries as {seq, exc, reg, data}
   logic [55:0] q[$];
   int          m_state;      // 0 off, 1 capturing, 2 frozen
   int          m_seq;
   int          m_drops;
   bit          m_ovf;

   function automatic void model_reset();
      q.delete();
      m_state = 0; m_seq = 0; m_drops = 0; m_ovf = 1'b0;
   endfunction

   function automatic void model_edge();
      bit is_event, captured, popped;
      if (clr) begin
         model_reset();
         return;
      end
      is_event = (we && wreg != 5'd0) || (wexc != 3'd0);
      captured = (m_state == 1) && is_event;
      popped   = (q.size() > 0) && rd_if.rd_ready;
      if (popped) void'(q.pop_front());
      if (captured) begin
         if (q.size() < DEPTH) q.push_back({m_seq[15:0], wexc, wreg, wdata});
         else begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
         end
         m_seq = (m_seq + 1) % 65536;
      end
      if (m_state == 0) begin
         if (en) m_state = 1;
      end else if (m_state == 1) begin
         if (captured && wexc != 3'd0 && frz) m_state = 2;
         else if (!en) m_state = 0;
      end
   endfunction

   task automatic cyc();
      @(posedge SYS_clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      we = 1'b0; wreg = 5'd0; wdata = 32'd0; wexc = 3'd0; clr = 1'b0;
   endtask

   task automatic ev(input logic w, input logic [4:0] r, input logic [31:0] d, input logic [2:0] x);
      we = w; wreg = r; wdata = d; wexc = x;
      cyc();
      idle();
   endtask

   task automatic drain();
      rd_if.rd_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) cyc();
      rd_if.rd_ready = 1'b0;
   endtask

   task automatic do_clear();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      SYS_reset = 1'b0;
      rd_if.rd_ready = 1'b0;
      idle();
      model_reset();
      #12;
      n_checks++;
      if ({rd_if.rd_valid, fill_level, overflow, dropped_count, frozen} !== 23'd0) begin
         $display("FAIL reset_flags got v=%0b fill=%0d ovf=%0b drop=%0d frz=%0b required all 0",
                  rd_if.rd_valid, fill_level, overflow, dropped_count, frozen);
         n_fail++;
      end
      n_checks++;
      if ({rd_if.rd_seq, rd_if.rd_exc, rd_if.rd_reg, rd_if.rd_data} !== 56'd0) begin
         $display("FAIL reset_head got seq=%0d exc=%0d reg=%0d data=%h required 0",
                  rd_if.rd_seq, rd_if.rd_exc, rd_if.rd_reg, rd_if.rd_data);
         n_fail++;
      end
      @(negedge SYS_clk);
      SYS_reset = 1'b1;
   endtask

   task automatic test_basic();
      en = 1'b1;
      cyc();
      ev(1'b1, 5'd8, 32'h0000_0005, 3'd0);
      n_checks++;
      if ({rd_if.rd_valid, rd_if.rd_reg, rd_if.rd_data, rd_if.rd_seq, rd_if.rd_exc} !==
          {1'b1, 5'd8, 32'd5, 16'd0, 3'd0}) begin
         $display("FAIL basic_push got v=%0b reg=%0d data=%h seq=%0d exc=%0d required 1/8/5/0/0",
                  rd_if.rd_valid, rd_if.rd_reg, rd_if.rd_data, rd_if.rd_seq, rd_if.rd_exc);
         n_fail++;
      end
      drain();
      n_checks++;
      if (fill_level !== 5'd0 || rd_if.rd_valid !== 1'b0) begin
         $display("FAIL basic_pop got fill=%0d v=%0b required 0/0", fill_level, rd_if.rd_valid);
         n_fail++;
      end
   endtask

   task automatic test_zero_reg();
      ev(1'b1, 5'd0, 32'hDEAD_BEEF, 3'd0);
      n_checks++;
      if (fill_level !== 5'd0) begin
         $display("FAIL r0_no_event got fill=%0d required 0", fill_level);
         n_fail++;
      end
      ev(1'b1, 5'd0, 32'h1234_5678, 3'd3);
      n_checks++;
      if ({rd_if.rd_valid, rd_if.rd_reg, rd_if.rd_exc, rd_if.rd_seq} !== {1'b1, 5'd0, 3'd3, 16'd1}) begin
         $display("FAIL r0_exc got v=%0b reg=%0d exc=%0d seq=%0d required 1/0/3/1",
                  rd_if.rd_valid, rd_if.rd_reg, rd_if.rd_exc, rd_if.rd_seq);
         n_fail++;
      end
      drain();
   endtask

   task automatic test_overflow();
      do_clear();
      for (int i = 0; i < 18; i++) ev(1'b1, 5'(i % 31 + 1), $urandom, 3'd0);
      n_checks++;
      if (fill_level !== 5'd16 || overflow !== 1'b1 || dropped_count !== 16'd2) begin
         $display("FAIL ovf_full got fill=%0d ovf=%0b drop=%0d required 16/1/2",
                  fill_level, overflow, dropped_count);
         n_fail++;
      end
      rd_if.rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (rd_if.rd_seq !== 16'(i) || rd_if.rd_data !== q[0][31:0]) begin
            $display("FAIL ovf_drain[%0d] got seq=%0d data=%h required seq=%0d data=%h",
                     i, rd_if.rd_seq, rd_if.rd_data, i, q[0][31:0]);
            n_fail++;
         end
         cyc();
      end
      rd_if.rd_ready = 1'b0;
      ev(1'b1, 5'd3, 32'hA5A5_0003, 3'd0);
      n_checks++;
      if (rd_if.rd_seq !== 16'd18 || fill_level !== 5'd1) begin
         $display("FAIL ovf_next_seq got seq=%0d fill=%0d required 18/1", rd_if.rd_seq, fill_level);
         n_fail++;
      end
      drain();
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < DEPTH; i++) ev(1'b1, 5'd9, 32'(i), 3'd0);
      rd_if.rd_ready = 1'b1;
      ev(1'b1, 5'd10, 32'hCAFE_0010, 3'd0);
      rd_if.rd_ready = 1'b0;
      n_checks++;
      if (fill_level !== 5'd16 || dropped_count !== 16'd2) begin
         $display("FAIL full_pop got fill=%0d drop=%0d required 16/2", fill_level, dropped_count);
         n_fail++;
      end
      rd_if.rd_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++;
         if ({rd_if.rd_seq, rd_if.rd_exc, rd_if.rd_reg, rd_if.rd_data} !== q[0]) begin
            $display("FAIL full_pop_drain[%0d] got %h required %h", i,
                     {rd_if.rd_seq, rd_if.rd_exc, rd_if.rd_reg, rd_if.rd_data}, q[0]);
            n_fail++;
         end
         cyc();
      end
      rd_if.rd_ready = 1'b0;
      n_checks++;
      if (rd_if.rd_data !== 32'hCAFE_0010 && fill_level !== 5'd0) begin
         $display("FAIL full_pop_last got fill=%0d required 0", fill_level);
         n_fail++;
      end
   endtask

   task automatic test_freeze();
      do_clear();
      frz = 1'b1;
      ev(1'b1, 5'd1, 32'hAAAA_0001, 3'd0);
      ev(1'b1, 5'd2, 32'hBBBB_0002, 3'd2);
      n_checks++;
      if (frozen !== 1'b1 || fill_level !== 5'd2) begin
         $display("FAIL freeze got frz=%0b fill=%0d required 1/2", frozen, fill_level);
         n_fail++;
      end
      ev(1'b1, 5'd3, 32'hCCCC_0003, 3'd0);
      n_checks++;
      if (fill_level !== 5'd2 || frozen !== 1'b1 || m_seq != 2) begin
         $display("FAIL freeze_ignore got fill=%0d frz=%0b required 2/1 (model seq %0d)",
                  fill_level, frozen, m_seq);
         n_fail++;
      end
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      n_checks++;
      if (fill_level !== 5'd0 || frozen !== 1'b0) begin
         $display("FAIL freeze_clear got fill=%0d frz=%0b required 0/0", fill_level, frozen);
         n_fail++;
      end
      ev(1'b1, 5'd4, 32'h0000_0044, 3'd0);   // still OFF on this edge
      ev(1'b1, 5'd5, 32'h0000_0055, 3'd0);   // now capturing
      n_checks++;
      if (fill_level !== 5'd1 || rd_if.rd_reg !== 5'd5 || rd_if.rd_seq !== 16'd0) begin
         $display("FAIL freeze_rerun got fill=%0d reg=%0d seq=%0d required 1/5/0",
                  fill_level, rd_if.rd_reg, rd_if.rd_seq);
         n_fail++;
      end
      frz = 1'b0;
      drain();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) ev(1'b1, 5'd7, 32'(100 + i), 3'd0);
      #2;
      SYS_reset = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (rd_if.rd_valid !== 1'b0 || fill_level !== 5'd0) begin
         $display("FAIL reset_mid got v=%0b fill=%0d required 0/0", rd_if.rd_valid, fill_level);
         n_fail++;
      end
      @(negedge SYS_clk);
      SYS_reset = 1'b1;
      cyc();
      ev(1'b1, 5'd6, 32'h0000_0066, 3'd0);
      n_checks++;
      if (rd_if.rd_seq !== 16'd0 || rd_if.rd_reg !== 5'd6 || fill_level !== 5'd1) begin
         $display("FAIL reset_mid_first got seq=%0d reg=%0d fill=%0d required 0/6/1",
                  rd_if.rd_seq, rd_if.rd_reg, fill_level);
         n_fail++;
      end
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         we    = 1'($urandom_range(0, 1));
         wreg  = 5'($urandom_range(0, 31));
         wdata = $urandom;
         wexc  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         en    = ($urandom_range(0, 15) != 0);
         frz   = ($urandom_range(0, 3) == 0);
         clr   = ($urandom_range(0, 39) == 0);
         rd_if.rd_ready = ($urandom_range(0, 2) == 0);
         cyc();
         n_checks++;
         if (fill_level !== 5'(q.size()) || overflow !== m_ovf ||
             dropped_count !== 16'(m_drops) || frozen !== (m_state == 2) ||
             rd_if.rd_valid !== (q.size() != 0)) begin
            $display("FAIL rand_flags[%0d] got fill=%0d ovf=%0b drop=%0d frz=%0b required %0d/%0b/%0d/%0b",
                     c, fill_level, overflow, dropped_count, frozen, q.size(), m_ovf, m_drops, m_state == 2);
            n_fail++;
         end
         if (q.size() != 0) begin
            n_checks++;
            if ({rd_if.rd_seq, rd_if.rd_exc, rd_if.rd_reg, rd_if.rd_data} !== q[0]) begin
               $display("FAIL rand_head[%0d] got %h required %h", c,
                        {rd_if.rd_seq, rd_if.rd_exc, rd_if.rd_reg, rd_if.rd_data}, q[0]);
               n_fail++;
            end
         end
      end
      idle();
      rd_if.rd_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_reg();
      test_overflow();
      test_full_pop();
      test_freeze();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
